// File: rtl/prog_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_pkg
// Description : Shared definitions for the program loader. Holds the loader
//               state encoding, the default memory geometry, the header magic
//               byte and the bit positions of the header word fields.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package prog_pkg;

    // Default memory geometry: 512 words of 32 bits, 4 bytes per word.
    localparam int PROG_ADDR_W         = 9;
    localparam int PROG_DATA_W         = 32;
    localparam int PROG_BYTES_PER_WORD = 4;

    // Required value of the first header byte.
    localparam logic [7:0] PROG_MAGIC = 8'hA5;

    // Header word layout: [31:24] magic, [23:15] base address, [8:0] count.
    // Bits [14:9] carry nothing and are ignored.
    localparam int HDR_MAGIC_MSB = 31;
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_BASE_LSB  = 15;
    localparam int HDR_CNT_LSB   = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage : prog_pkg
`default_nettype wire

// File: rtl/prog_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Assembles four accepted bytes, MSB first, into one 32-bit
//               word. The first byte lands in [31:24], the fourth in [7:0].
//               word_valid is a combinational pulse in the cycle the fourth
//               byte is accepted, so the consumer can register the word on
//               that same edge.
// Ports       : clk        in   clock
//               reset      in   synchronous active-high reset
//               clear      in   synchronous restart of the byte counter
//               accept     in   a byte is being consumed this cycle
//               byte_in    in   the byte being consumed
//               word       out  completed word (valid with word_valid)
//               word_valid out  fourth byte of a word accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import prog_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_BYTE = 2'(PROG_BYTES_PER_WORD - 1);

    logic [1:0]  byte_cnt;
    logic [23:0] hold;      // first three bytes of the word in progress

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_cnt <= 2'd0;
            hold     <= 24'd0;
        end else if (accept) begin
            // The counter wraps 3 -> 0 naturally; the stale content of hold
            // after a word completes is fully shifted out by the next word.
            byte_cnt <= byte_cnt + 2'd1;
            hold     <= {hold[15:0], byte_in};
        end
    end

    assign word       = {hold, byte_in};
    assign word_valid = accept && (byte_cnt == LAST_BYTE);

endmodule : byte_packer
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Loads a program image from a host byte link into program
//               memory. A frame is a header word (magic, base, count N), N
//               data words and an XOR checksum word. The processor is held
//               while loading and released only after a good checksum.
// Ports       : clk          in   clock
//               reset        in   synchronous active-high reset
//               start        in   one-cycle pulse, arms / restarts a load
//               in_valid     in   host byte valid
//               in_data      in   host byte
//               in_ready     out  loader accepts a byte this cycle
//               mem_we       out  memory write strobe, one cycle per word
//               mem_addr     out  word address of the write
//               mem_wdata    out  word written
//               cpu_hold     out  processor must stall while high
//               done         out  one-cycle pulse on a successful load
//               error        out  sticky error, cleared by start or reset
//               words_loaded out  data words written in current/last load
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_pkg::*;
#(
    parameter int         ADDR_W = PROG_ADDR_W,
    parameter int         DATA_W = PROG_DATA_W,
    parameter logic [7:0] MAGIC  = PROG_MAGIC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);

    state_t state;
    state_t state_next;

    logic [31:0]       word;
    logic              word_valid;
    logic              accept;

    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] remaining;
    logic [DATA_W-1:0] xor_acc;

    logic [ADDR_W-1:0] hdr_base;
    logic [ADDR_W-1:0] hdr_count;
    logic              hdr_bad;

    // Strobes from the control process to the datapath.
    logic              do_start;
    logic              do_hdr;
    logic              do_write;
    logic              do_release;

    // A byte offered in the same cycle as start is dropped: the restarted
    // load must begin with a fresh header.
    assign accept = in_valid && in_ready && !start;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (do_start),
        .accept     (accept),
        .byte_in    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    assign hdr_base  = word[HDR_BASE_LSB +: ADDR_W];
    assign hdr_count = word[HDR_CNT_LSB  +: ADDR_W];
    assign hdr_bad   = (word[HDR_MAGIC_MSB:HDR_MAGIC_LSB] != MAGIC) ||
                       (hdr_count == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_hdr     = 1'b0;
        do_write   = 1'b0;
        do_release = 1'b0;
        in_ready   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    do_start   = 1'b1;
                    state_next = HDR;
                end
            end

            HDR: begin
                in_ready = 1'b1;
                if (start) begin
                    do_start   = 1'b1;
                    state_next = HDR;
                end else if (word_valid) begin
                    if (hdr_bad) begin
                        state_next = ERR;
                    end else begin
                        do_hdr     = 1'b1;
                        state_next = DATA;
                    end
                end
            end

            DATA: begin
                in_ready = 1'b1;
                if (start) begin
                    do_start   = 1'b1;
                    state_next = HDR;
                end else if (word_valid) begin
                    do_write = 1'b1;
                    if (remaining == ADDR_W'(1)) begin
                        state_next = CSUM;
                    end
                end
            end

            CSUM: begin
                in_ready = 1'b1;
                if (start) begin
                    do_start   = 1'b1;
                    state_next = HDR;
                end else if (word_valid) begin
                    if (word == xor_acc) begin
                        // cpu_hold drops on this edge so it is already low
                        // during the done pulse.
                        do_release = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = ERR;
                    end
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            ERR: begin
                error = 1'b1;
                if (start) begin
                    do_start   = 1'b1;
                    state_next = HDR;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: write port, address/remaining counters, checksum, hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            words_loaded <= '0;
            addr_cnt     <= '0;
            remaining    <= '0;
            xor_acc      <= '0;
        end else begin
            mem_we <= 1'b0;

            if (do_start) begin
                cpu_hold     <= 1'b1;
                words_loaded <= '0;
            end

            if (do_hdr) begin
                addr_cnt  <= hdr_base;
                remaining <= hdr_count;
                xor_acc   <= '0;
            end

            if (do_write) begin
                mem_we       <= 1'b1;
                mem_addr     <= addr_cnt;
                mem_wdata    <= word;
                addr_cnt     <= addr_cnt + ADDR_W'(1);  // wraps at 2^ADDR_W
                remaining    <= remaining - ADDR_W'(1);
                xor_acc      <= xor_acc ^ word;
                words_loaded <= words_loaded + ADDR_W'(1);
            end

            if (do_release) begin
                cpu_hold <= 1'b0;
            end
        end
    end

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed self-checking bench for prog_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int checks   = 0;
    int errors   = 0;
    int we_count = 0;
    int gap_seed = 0;
    bit gap_mode = 1'b0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always @(posedge clk) begin
        if (mem_we === 1'b1) we_count <= we_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte's edge.
    task automatic send_byte(input logic [7:0] b, input bit exp_we,
                             input logic [8:0] exp_addr, input logic [31:0] exp_data);
        int gap;
        gap = gap_mode ? (gap_seed % 3) : 0;
        gap_seed++;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
            chk("gap_in_ready", in_ready, 1);
            chk("gap_mem_we", mem_we, 0);
        end
        in_valid = 1'b1;
        in_data  = b;
        chk("in_ready", in_ready, 1);
        @(negedge clk);
        chk("mem_we", mem_we, exp_we);
        if (exp_we) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, exp_data);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit exp_we, input logic [8:0] exp_addr);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], exp_we && (i == 3), exp_addr, w);
        end
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_words", words_loaded, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);

        // Good 3-word load at base 1, back to back.
        pulse_start();
        chk("t1_hold", cpu_hold, 1);
        chk("t1_error", error, 0);
        send_word(32'hA500_8003, 0, 0);
        send_word(32'h0000_0001, 1, 9'd1);
        send_word(32'h0000_0002, 1, 9'd2);
        send_word(32'h0000_0004, 1, 9'd3);
        send_word(32'h0000_0007, 0, 0);
        in_valid = 1'b0;
        chk("t1_done", done, 1);
        chk("t1_hold_rel", cpu_hold, 0);
        chk("t1_words", words_loaded, 3);
        chk("t1_error_end", error, 0);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        chk("t1_idle_ready", in_ready, 0);
        chk("t1_hold_low", cpu_hold, 0);

        // Same frame with a bad checksum.
        pulse_start();
        chk("t2_hold", cpu_hold, 1);
        send_word(32'hA500_8003, 0, 0);
        send_word(32'h0000_0001, 1, 9'd1);
        send_word(32'h0000_0002, 1, 9'd2);
        send_word(32'h0000_0004, 1, 9'd3);
        send_word(32'h0000_0006, 0, 0);
        in_valid = 1'b0;
        chk("t2_error", error, 1);
        chk("t2_done", done, 0);
        chk("t2_hold", cpu_hold, 1);
        chk("t2_in_ready", in_ready, 0);
        chk("t2_words", words_loaded, 3);
        @(negedge clk);
        chk("t2_error_sticky", error, 1);
        pulse_start();
        chk("t2_error_clr", error, 0);
        chk("t2_words_clr", words_loaded, 0);
        chk("t2_retry_ready", in_ready, 1);

        // Bad magic, then zero word count.
        send_word(32'h5A00_8003, 0, 0);
        in_valid = 1'b0;
        chk("t3_magic_err", error, 1);
        pulse_start();
        send_word(32'hA500_8000, 0, 0);
        in_valid = 1'b0;
        chk("t3_zero_err", error, 1);
        chk("t3_hold", cpu_hold, 1);
        chk("t3_we_count", we_count, 6);

        // Base 511 wraps to 0.
        pulse_start();
        send_word(32'hA5FF_8002, 0, 0);
        send_word(32'h1111_1111, 1, 9'd511);
        send_word(32'h2222_2222, 1, 9'd0);
        send_word(32'h3333_3333, 0, 0);
        in_valid = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_words", words_loaded, 2);

        // First frame again with idle gaps inside words.
        gap_mode = 1'b1;
        pulse_start();
        send_word(32'hA500_8003, 0, 0);
        send_word(32'h0000_0001, 1, 9'd1);
        send_word(32'h0000_0002, 1, 9'd2);
        send_word(32'h0000_0004, 1, 9'd3);
        send_word(32'h0000_0007, 0, 0);
        in_valid = 1'b0;
        gap_mode = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_words", words_loaded, 3);

        // Restart mid-load with a byte offered alongside start, then reset
        // while a word is one byte from completion.
        pulse_start();
        send_word(32'hA500_8003, 0, 0);
        send_word(32'h0000_0001, 1, 9'd1);
        chk("t6_words_pre", words_loaded, 1);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("t6_restart_words", words_loaded, 0);
        chk("t6_restart_ready", in_ready, 1);
        chk("t6_restart_we", mem_we, 0);
        chk("t6_restart_hold", cpu_hold, 1);
        send_word(32'hA500_8003, 0, 0);
        send_word(32'h0000_0001, 1, 9'd1);
        chk("t6_words_mid", words_loaded, 1);
        send_byte(8'h00, 0, 0, 0);
        send_byte(8'h00, 0, 0, 0);
        send_byte(8'h00, 0, 0, 0);
        in_valid = 1'b1;
        in_data  = 8'h02;
        reset    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_rst_we", mem_we, 0);
        chk("t6_rst_ready", in_ready, 0);
        chk("t6_rst_hold", cpu_hold, 1);
        chk("t6_rst_words", words_loaded, 0);
        chk("t6_rst_error", error, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_post_we", mem_we, 0);
        chk("t6_post_ready", in_ready, 0);
        chk("total_we_count", we_count, 13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction/data memory port: takes a byte stream from a host link, assembles 32-bit words and writes them into the program memory through the same we/addr/wdata interface the processor uses for reads.
- Holds the processor (cpu_hold) while a program image is loaded and checksummed, then releases it.
- Sits between the host byte link and the memory write mux. Owns the memory port while cpu_hold=1.

Parameters:
- ADDR_W, 9, memory word-address width (512 words).
- DATA_W, 32, memory word width. Fixed at 4 bytes per word.
- MAGIC, 8'hA5, required value of header byte 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; arms a new load.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader accepts a byte when in_valid && in_ready.
- mem_we  out  1  memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  DATA_W  word written.
- cpu_hold  out  1  processor must stall and not drive memory while high.
- done  out  1  one-cycle pulse on successful load.
- error  out  1  sticky error flag; cleared by start or reset.
- words_loaded  out  ADDR_W  count of data words written in the current or last load.

Behaviour:
- Reset values:
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1: the processor stays stalled until the first successful load.
  - done=0, error=0, words_loaded=0.
- Byte assembly:
  - Bytes are MSB first: the first accepted byte goes to [31:24] and the fourth to [7:0].
  - A 2-bit byte counter wraps from 3 to 0 when a word completes.
- Frame format:
  - Header word: [31:24]=MAGIC, [23:15]=base address, [8:0]=word count N. Bits [14:9] are ignored.
  - Then N data words.
  - Then one checksum word: the XOR of all N data words.
- States:
  - IDLE: in_ready=0. start moves to HDR, sets cpu_hold=1, clears error, words_loaded and the byte counter.
  - HDR: in_ready=1. When the 4th byte is accepted, the header is checked:
    - byte0 != MAGIC or N=0 -> ERR.
    - Otherwise latch base into the address counter and N into the remaining counter, clear the running XOR, go to DATA.
  - DATA: in_ready=1. Each completed word, in the next cycle, gives mem_we=1, mem_addr=address counter, mem_wdata=word. Then:
    - address counter +1, wrapping modulo 2^ADDR_W (511+1 -> 0).
    - XOR updated, remaining-1, words_loaded+1.
    - When remaining reaches 0, go to CSUM.
  - CSUM: in_ready=1. On the completed word:
    - match with the XOR -> DONE.
    - mismatch -> ERR.
  - DONE: lasts one cycle. done=1, cpu_hold falls to 0 in the same cycle, then IDLE.
  - ERR: error=1, cpu_hold stays 1, in_ready=0. Stays until start (retry -> HDR) or reset.
- Write latency: mem_we is asserted exactly 1 cycle after the handshake of the word's 4th byte.
  - Back-to-back bytes (in_valid held high) are accepted every cycle with no stall.
  - in_ready never drops inside HDR, DATA or CSUM.
- Gaps: in_valid low for any number of cycles is legal mid-word. No timeout.
- start received in HDR, DATA or CSUM: the load aborts and restarts in HDR.
  - Any byte offered in that cycle is dropped.
  - Writes already made remain in memory.
- start in DONE: ignored; it takes effect only from IDLE or ERR.
- Reset mid-load: all counters clear, and no mem_we is issued in the cycle after reset even if a word was pending.
- Words already written before an error are not rolled back. cpu_hold=1 prevents their use.

Decomposition:
- Shared package prog_pkg holds:
  - state enum (IDLE, HDR, DATA, CSUM, DONE, ERR).
  - MAGIC, the header field bit positions, ADDR_W and DATA_W.
- One natural sub-module: byte_packer (8->32 assembler, byte counter, word_valid pulse, clear input).

Test Plan:
- Reset, start, then bytes A5 00 80 03 (base=1, N=3), words 0x00000001 0x00000002 0x00000004, checksum 0x00000007 -> three mem_we pulses at addr 1,2,3, each 1 cycle after the word's last byte; done pulse; cpu_hold 1->0; words_loaded=3.
- Same frame with checksum 0x00000006 -> three writes occur; error=1, cpu_hold=1, no done; a following start clears error.
- Header byte0=0x5A, or N=0 -> ERR after the 4th header byte; no mem_we ever asserted.
- base=511, N=2 -> writes at addr 511 then 0 (wrap).
- in_valid toggled randomly with gaps mid-word -> the same write data/addresses as the back-to-back case; in_ready stays 1 throughout.
- start pulse after the 1st data word of a 3-word load, then reset during the 2nd word of the restarted load -> restart reissues the header check; after reset no mem_we, state=IDLE, cpu_hold=1, words_loaded=0.
